// File: rtl/gg_enc_pkg.sv
// Shared types and helpers for the encoder bitstream writers.
package gg_enc_pkg;

    localparam int GG_MAXLEN = 32;

    typedef enum logic [1:0] {RUN, TRAIL, DRAIN} pack_state_t;

    function automatic int ceil8(input int x);
        return (x + 7) & ~7;
    endfunction

    function automatic logic [GG_MAXLEN-1:0] len_mask(input int len);
        logic [GG_MAXLEN-1:0] m;
        for (int i = 0; i < GG_MAXLEN; i++) m[i] = (i < len);
        return m;
    endfunction

endpackage

// File: rtl/gg_bit_insert.sv
// Places a masked code (and optional start mark) into a left-aligned
// WID+MAXLEN vector so its first bit lands at offset 'off' from the top.
module gg_bit_insert
    import gg_enc_pkg::*;
#(
    parameter int WID    = 128,
    parameter int MAXLEN = GG_MAXLEN
) (
    input  logic [$clog2(WID+MAXLEN+1)-1:0] off,
    input  logic [MAXLEN-1:0]               code,
    input  logic [$clog2(MAXLEN+1)-1:0]     len,
    input  logic                            mark,
    output logic [WID+MAXLEN-1:0]           code_vec,
    output logic [WID+MAXLEN-1:0]           mark_vec
);
    localparam int TOT = WID + MAXLEN;

    always_comb begin
        code_vec = '0;
        mark_vec = '0;
        // Zero-length symbols contribute nothing, not even a mark.
        if (len != '0 && (int'(off) + int'(len)) <= TOT) begin
            code_vec = TOT'(code & len_mask(int'(len))) << (TOT - int'(off) - int'(len));
            mark_vec = TOT'(mark) << (TOT - 1 - int'(off));
        end
    end

endmodule

// File: rtl/gg_vlc_bit_packer.sv
// Packs variable-length codes into big-endian words with aligned start marks;
// a flush appends RBSP trailing bits and drains the final partial word.
module gg_vlc_bit_packer
    import gg_enc_pkg::*;
#(
    parameter int WID    = 128,
    parameter int MAXLEN = GG_MAXLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAXLEN-1:0]             in_code,
    input  logic [$clog2(MAXLEN+1)-1:0]   in_len,
    input  logic                          in_mark,
    input  logic                          in_flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WID-1:0]                out_bits,
    output logic [WID-1:0]                out_mark,
    output logic [$clog2(WID+1)-1:0]      out_nbits,
    output logic                          out_last
);
    localparam int TOT = WID + MAXLEN;
    localparam int FW  = $clog2(TOT + 1);
    localparam int NW  = $clog2(WID + 1);

    logic [TOT-1:0] acc, acc_n, acc_b, ins_code;
    logic [TOT-1:0] mrk, mrk_n, mrk_b, ins_mark;
    logic [FW-1:0]  fill, fill_n, fill_b;
    pack_state_t    state, state_n;
    logic           accept, emit, last_word;

    gg_bit_insert #(.WID(WID), .MAXLEN(MAXLEN)) u_insert (
        .off      (fill_b),
        .code     (in_code),
        .len      (in_len),
        .mark     (in_mark),
        .code_vec (ins_code),
        .mark_vec (ins_mark)
    );

    always_comb begin
        in_ready  = (state == RUN) && (fill <= FW'(WID));
        last_word = (state == DRAIN) && (fill <= FW'(WID));
        out_valid = ((state == RUN) && (fill >= FW'(WID))) || (state == DRAIN);
        out_bits  = '0;
        out_mark  = '0;
        out_nbits = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            // Bits past 'fill' are always zero, so a partial word needs no masking.
            out_bits  = acc[TOT-1 -: WID];
            out_mark  = mrk[TOT-1 -: WID];
            out_nbits = last_word ? NW'(fill) : NW'(WID);
            out_last  = last_word;
        end
        accept = in_valid && in_ready;
        emit   = out_valid && out_ready;
    end

    // The word leaves first, so a same-cycle symbol lands at fill-WID.
    always_comb begin
        acc_b  = emit ? (acc << WID) : acc;
        mrk_b  = emit ? (mrk << WID) : mrk;
        fill_b = emit ? (fill - FW'(WID)) : fill;
    end

    always_comb begin
        acc_n   = acc_b;
        mrk_n   = mrk_b;
        fill_n  = fill_b;
        state_n = state;
        unique case (state)
            RUN: begin
                if (accept) begin
                    acc_n  = acc_b | ins_code;
                    mrk_n  = mrk_b | ins_mark;
                    fill_n = fill_b + FW'(in_len);
                    if (in_flush) state_n = TRAIL;
                end
            end
            TRAIL: begin
                acc_n   = acc | (TOT'(1) << (TOT - 1 - int'(fill)));
                fill_n  = FW'(ceil8(int'(fill) + 1));
                state_n = DRAIN;
            end
            DRAIN: begin
                if (emit && last_word) begin
                    acc_n   = '0;
                    mrk_n   = '0;
                    fill_n  = '0;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            mrk   <= '0;
            fill  <= '0;
            state <= RUN;
        end else begin
            acc   <= acc_n;
            mrk   <= mrk_n;
            fill  <= fill_n;
            state <= state_n;
        end
    end

endmodule

// File: tb/tb_gg_vlc_bit_packer.sv
// Bench for gg_vlc_bit_packer: bit-queue reference model, directed table, random traffic.
module tb_gg_vlc_bit_packer;
    localparam int WID    = 128;
    localparam int MAXLEN = 32;

    logic             clk, reset;
    logic             in_valid, in_ready, in_mark, in_flush;
    logic [31:0]      in_code;
    logic [5:0]       in_len;
    logic             out_valid, out_ready, out_last;
    logic [WID-1:0]   out_bits, out_mark;
    logic [7:0]       out_nbits;

    gg_vlc_bit_packer #(.WID(WID), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_len(in_len),
        .in_mark(in_mark), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_mark(out_mark), .out_nbits(out_nbits), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    bit q[$];
    bit mq[$];
    bit flushing = 0;
    bit got_word, seen_last;
    int words_seen = 0;
    logic [WID-1:0] got_bits, got_mark, hold;
    logic [7:0]     got_nbits;

    task automatic chk(input string name, input logic [WID-1:0] got, input logic [WID-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mq.delete();
        flushing = 0;
    endtask

    // One clock: drive, check against the bit-stream model at negedge, update it.
    task automatic cycle(input logic v, input logic [31:0] code, input int len,
                         input logic mk, input logic fl, input logic rdy);
        logic [WID-1:0] eb, em;
        bit exp_last;
        int en;
        in_valid = v; in_code = code; in_len = 6'(len); in_mark = mk;
        in_flush = fl; out_ready = rdy;
        got_word = 0;
        @(negedge clk);
        if (!flushing) begin
            chk("in_ready", WID'(in_ready), WID'(q.size() <= WID));
            chk("out_valid", WID'(out_valid), WID'(q.size() >= WID));
        end else begin
            chk("in_ready_busy", WID'(in_ready), '0);
        end
        if (out_valid && out_ready) begin
            exp_last = flushing && (q.size() <= WID);
            en = exp_last ? q.size() : WID;
            eb = '0; em = '0;
            if (q.size() < en) begin
                n_checks++; n_fail++;
                $display("FAIL underflow: word emitted with %0d bits queued", q.size());
                en = q.size();
            end
            for (int i = 0; i < en; i++) begin
                eb[WID-1-i] = q[i];
                em[WID-1-i] = mq[i];
            end
            chk("out_bits", out_bits, eb);
            chk("out_mark", out_mark, em);
            chk("out_nbits", WID'(out_nbits), WID'(en));
            chk("out_last", WID'(out_last), WID'(exp_last));
            for (int i = 0; i < en; i++) begin
                void'(q.pop_front());
                void'(mq.pop_front());
            end
            if (exp_last) flushing = 0;
            got_word = 1; words_seen++;
            got_bits = out_bits; got_mark = out_mark; got_nbits = out_nbits;
            if (out_last) seen_last = 1;
        end
        if (in_valid && in_ready) begin
            for (int i = len - 1; i >= 0; i--) begin
                q.push_back(code[i]);
                mq.push_back(mk && (i == len - 1));
            end
            if (fl) begin
                q.push_back(1'b1); mq.push_back(1'b0);
                while (q.size() % 8 != 0) begin q.push_back(1'b0); mq.push_back(1'b0); end
                flushing = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 0, 1'b0, 1'b0, rdy);
    endtask

    typedef struct {
        logic [31:0] code;
        int          len;
        logic        mk;
        logic [63:0] exp_hi;
        int          exp_n;
        logic        exp_m;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [127:0] mb;
        int lens[8];
        int pos;
        bit issued;

        tbl[0] = '{32'h1,         1,  1'b1, 64'hC000_0000_0000_0000,  8, 1'b1};
        tbl[1] = '{32'h0,         0,  1'b1, 64'h8000_0000_0000_0000,  8, 1'b0};
        tbl[2] = '{32'h7F,        7,  1'b0, 64'hFF00_0000_0000_0000,  8, 1'b0};
        tbl[3] = '{32'hFF,        8,  1'b1, 64'hFF80_0000_0000_0000, 16, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 4,  1'b0, 64'hF800_0000_0000_0000,  8, 1'b0};
        tbl[5] = '{32'hDEAD_BEEF, 32, 1'b0, 64'hDEAD_BEEF_8000_0000, 40, 1'b0};
        tbl[6] = '{32'h0,         32, 1'b1, 64'h0000_0000_8000_0000, 40, 1'b1};
        tbl[7] = '{32'hFFFF_FFF5, 3,  1'b0, 64'hB000_0000_0000_0000,  8, 1'b0};

        in_valid = 0; in_code = 0; in_len = 0; in_mark = 0; in_flush = 0; out_ready = 0;
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        #1;
        chk("rst_out_valid", WID'(out_valid), '0);
        chk("rst_out_bits", out_bits, '0);
        chk("rst_out_nbits", WID'(out_nbits), '0);
        chk("rst_in_ready", WID'(in_ready), WID'(1));
        @(posedge clk); #1;

        // Four full symbols make exactly one word, visible the cycle after the 4th accept.
        repeat (4) cycle(1'b1, 32'hDEAD_BEEF, 32, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("full_word_seen", WID'(got_word), WID'(1));
        chk("full_word_bits", got_bits, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        chk("full_word_nbits", WID'(got_nbits), WID'(128));
        chk("full_word_mark", got_mark, '0);

        // Single-symbol flushes from an empty packer.
        foreach (tbl[k]) begin
            seen_last = 0;
            cycle(1'b1, tbl[k].code, tbl[k].len, tbl[k].mk, 1'b1, 1'b1);
            for (int c = 0; c < 10 && !seen_last; c++) idle(1'b1);
            if (!seen_last) begin
                n_checks++; n_fail++;
                $display("FAIL tbl%0d_timeout: no last word within 10 cycles", k);
            end else begin
                chk($sformatf("tbl%0d_bits", k), got_bits, {tbl[k].exp_hi, 64'h0});
                chk($sformatf("tbl%0d_nbits", k), WID'(got_nbits), WID'(tbl[k].exp_n));
                chk($sformatf("tbl%0d_mark", k), got_mark, tbl[k].exp_m ? {1'b1, 127'h0} : '0);
            end
            chk($sformatf("tbl%0d_ready_after", k), WID'(in_ready), WID'(1));
        end

        // Backpressure: fill to 160, hold output stable, then release.
        for (int s = 0; s < 5; s++) cycle(1'b1, 32'h1000_0000 + s, 32, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", WID'(in_ready), '0);
        hold = out_bits;
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, 32'hAAAA_AAAA, 32, 1'b0, 1'b0, 1'b0);
            chk("bp_stable", out_bits, hold);
        end
        idle(1'b1);
        chk("bp_word", got_bits, 128'h10000000_10000001_10000002_10000003);
        chk("bp_in_ready_back", WID'(in_ready), WID'(1));
        chk("bp_out_valid_low", WID'(out_valid), '0);
        seen_last = 0;
        cycle(1'b1, 32'h0, 0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 10 && !seen_last; c++) idle(1'b1);
        chk("bp_flush_last", WID'(seen_last), WID'(1));
        chk("bp_flush_bits", got_bits, {32'h10000004, 8'h80, 88'h0});

        // A 128-bit block split into odd-length symbols, first one marked.
        mb = 128'h0123456789ABCDEF_FEDCBA9876543210;
        lens = '{32, 1, 7, 24, 16, 3, 13, 32};
        pos = 128;
        for (int s = 0; s < 8; s++) begin
            pos -= lens[s];
            cycle(1'b1, 32'(mb >> pos), lens[s], s == 0, 1'b0, 1'b1);
        end
        idle(1'b1);
        chk("mb_bits", got_bits, mb);
        chk("mb_mark", got_mark, {1'b1, 127'h0});

        // Reset in the middle of a drain: 150 bits buffered, one word out, then reset.
        for (int s = 0; s < 4; s++) cycle(1'b1, $urandom, 32, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 22, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("rd_first_word", WID'(got_word), WID'(1));
        chk("rd_drain_valid", WID'(out_valid), WID'(1));
        reset = 0;
        #1;
        chk("rd_valid_now_low", WID'(out_valid), '0);
        chk("rd_last_now_low", WID'(out_last), '0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1;
        @(posedge clk); #1;
        chk("rd_in_ready", WID'(in_ready), WID'(1));
        words_seen = 0;
        repeat (5) idle(1'b1);
        chk("rd_no_words", WID'(words_seen), '0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int   len  = $urandom_range(0, MAXLEN);
            logic v    = ($urandom % 5) != 0;
            logic fl   = (($urandom % 40) == 0) && (q.size() + len <= WID + MAXLEN - 8);
            cycle(v, $urandom, len, ($urandom % 6) == 0, fl, ($urandom % 4) != 0);
        end
        issued = 0;
        for (int c = 0; c < 100; c++) begin
            if (!flushing && q.size() <= WID && !issued) begin
                cycle(1'b1, 32'h0, 0, 1'b0, 1'b1, 1'b1);
                issued = 1;
            end else begin
                idle(1'b1);
            end
            if (issued && !flushing) break;
        end
        if (flushing || !issued) begin
            n_checks++; n_fail++;
            $display("FAIL final_drain: flush did not complete within 100 cycles");
        end
        chk("final_empty", WID'(q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gg_vlc_bit_packer.md
Name: gg_vlc_bit_packer

Overview:
Packs variable-length codes (CAVLC / exp-Golomb symbols) into big-endian WID-bit words for the encoder output path. Each word is laid out exactly as the parse lattice consumes it: bit WID-1 is the first bitstream bit. A one-hot start-marker vector travels alongside each word, so a tagged symbol's first bit can drive mb_start on the parser side. A flush request appends the RBSP trailing bits (stop bit 1, then zeros to a byte boundary) and drains the final partial word.

Parameters:
WID, 128, output word width in bits; must be a multiple of 8 and at least MAXLEN.
MAXLEN, 32, maximum symbol length in bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  symbol present
in_ready  output  1  symbol accepted when in_valid && in_ready
in_code  input  MAXLEN  code, right-aligned; bits at or above in_len are ignored (masked)
in_len  input  $clog2(MAXLEN+1)  symbol length, 0..MAXLEN
in_mark  input  1  tag the first bit of this symbol in out_mark
in_flush  input  1  with an accepted symbol: append the symbol, then the trailing bits, then drain
out_valid  output  1  word present
out_ready  input  1  word consumed when out_valid && out_ready
out_bits  output  WID  packed bits, MSB first; unused LSBs are 0
out_mark  output  WID  one-hot (or multi-hot) start markers aligned to out_bits
out_nbits  output  $clog2(WID+1)  valid bits in out_bits: WID, or a byte multiple on the last word
out_last  output  1  final word of a flush

Behaviour:
- Storage: acc[WID+MAXLEN-1:0] and mrk[WID+MAXLEN-1:0], both left-aligned, plus a fill counter (0..WID+MAXLEN).
- Reset (async, reset=0): acc=0, mrk=0, fill=0, state=RUN. All outputs 0 except in_ready=1 once reset is released.
- Accept: the masked code is written at acc bits [top-fill -: in_len]. If in_mark && in_len>0, mrk[top-fill]=1. If in_len=0, nothing changes and in_mark is ignored.
- in_ready = (state==RUN) && (fill <= WID).
- out_valid in RUN = (fill >= WID). out_bits = acc top WID bits, out_nbits=WID, out_last=0.
- Emit: acc and mrk shift left by WID; fill -= WID.
- Simultaneous emit and accept in one cycle: the new symbol is placed at position fill-WID after the shift. Next fill = fill - WID + in_len.
- Latency: a word becomes out_valid the cycle after the accept that brings fill to WID or above. Throughput is one symbol per cycle, one word per cycle.
- States:
  - RUN: accept with in_flush=1 goes to TRAIL. In_ready is 0 in every state except RUN.
  - TRAIL (one cycle): append 1 at fill, then zeros to the next byte boundary; fill = ceil8(fill+1). Go to DRAIN.
  - DRAIN, fill > WID: emit a full word (out_last=0), stay in DRAIN.
  - DRAIN, fill <= WID: present the remaining bits with out_nbits=fill, out_last=1, LSBs zeroed. On out_ready: fill=0, acc=0, mrk=0, go to RUN.
- Backpressure: with out_ready=0, out_bits, out_mark, out_nbits and out_last hold stable while out_valid=1. Accepts continue until fill > WID.
- Fill never exceeds WID+MAXLEN. Precondition: TRAIL is entered only with fill <= WID+MAXLEN-8.
- Reset asserted mid-operation discards all buffered bits. No partial word is emitted.

Decomposition:
- Package gg_enc_pkg:
  - MAXLEN default.
  - typedef enum {RUN, TRAIL, DRAIN} pack_state_t.
  - Function ceil8().
  - Function len_mask(len), returning an MAXLEN-bit mask.
- Sub-module gg_bit_insert: combinational placement of a masked code and mark into the acc/mrk vectors at a given fill offset. It is reused later by the exp-Golomb writer.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> out_valid=0, out_bits=0, in_ready=1, fill=0.
- Full words: 4 accepts of code 32'hDEADBEEF, len 32, with out_ready=1 -> one word 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, out_nbits=128, out_last=0, out_mark=0.
- Mark and flush: code 1'b1, len 1, in_mark=1, in_flush=1 -> out_bits[127:120]=8'hC0, rest 0, out_nbits=8, out_last=1, out_mark[127]=1; in_ready then returns to 1.
- Backpressure: out_ready=0; push 5 symbols of len 32 (fill=160) -> in_ready=0 after the 5th, out_bits stable. Raise out_ready -> word emitted, fill=32, in_ready=1.
- Lattice round trip: push the 128-bit test macroblock as a sequence of symbols, first symbol marked -> out_bits equals the test vector and out_mark[127]=1. Feed both into gg_parse_lattice_macroblock -> decoded block ends match the direct-stimulus run.
- Reset during DRAIN: flush with 150 bits buffered, then assert reset after the first word -> out_valid=0 immediately. After release: fill=0, no out_last word is produced.
